// File: rtl/weight_fetch_pkg.sv
// Shared types and constants for the weight fetch sequencer.
package weight_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } wf_state_e;

    localparam int unsigned WF_FIFO_DEPTH = 2;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding returned ROM words (data + channel tag); head register drives outputs.
module weight_skid_fifo
    import weight_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [1:0]       occ_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [1:0] Full = 2'(WF_FIFO_DEPTH);

    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             pop_eff;
    logic [1:0]       wr_slot;

    always_comb begin
        pop_eff = pop_i & (occ_q != 2'd0);
        occ_d   = occ_q + {1'b0, push_i} - {1'b0, pop_eff};
        // Slot the incoming word lands in after this cycle's pop has shifted the queue.
        wr_slot = occ_q - {1'b0, pop_eff};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Payload needs no reset: it is only observed while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        if (pop_eff && occ_q == Full) begin
            head_q <= tail_q;
        end
        if (push_i) begin
            if (wr_slot == 2'd0) begin
                head_q <= data_i;
            end else begin
                tail_q <= data_i;
            end
        end
    end

    assign occ_o   = occ_q;
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = head_q;

endmodule

// File: rtl/weight_fetch.sv
// Walks channel addresses into the weight ROM and streams returned words to the conv engine.
module weight_fetch
    import weight_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 2304,
    parameter int unsigned NUM_CH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_q_i,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [ADDR_WIDTH-1:0] w_ch_o,
    output logic                  w_last_o
);

    localparam int unsigned          FifoWidth = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastCh   = ADDR_WIDTH'(NUM_CH - 1);

    wf_state_e             state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] issued_ch_q;
    logic                  inflight_q;
    logic                  done_q;
    logic                  busy_q;

    logic                  pop;
    logic                  issue;
    logic [2:0]            fill;
    logic [1:0]            occ;
    logic                  head_valid;
    logic [FifoWidth-1:0]  head;
    logic [ADDR_WIDTH-1:0] head_ch;

    always_comb begin
        pop   = head_valid & w_ready_i;
        // Words already buffered plus the one in flight, net of this cycle's pop, must leave room.
        fill  = {1'b0, occ} + {2'b0, inflight_q};
        issue = (state_q == StFetch) && (fill < (3'd2 + {2'b0, pop}));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            issued_ch_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                issued_ch_q <= cnt_q;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StFetch;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        if (cnt_q == LastCh) begin
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                StDrain: begin
                    if (pop && w_last_o) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    weight_skid_fifo #(
        .WIDTH (FifoWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (inflight_q),
        .data_i  ({rom_q_i, issued_ch_q}),
        .pop_i   (pop),
        .occ_o   (occ),
        .valid_o (head_valid),
        .data_o  (head)
    );

    assign head_ch    = head[ADDR_WIDTH-1:0];
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rom_addr_o = cnt_q;
    assign w_valid_o  = head_valid;
    assign w_data_o   = head[FifoWidth-1:ADDR_WIDTH];
    assign w_ch_o     = head_valid ? head_ch : '0;
    assign w_last_o   = head_valid && (head_ch == LastCh);

endmodule
